// File: rtl/rptr_empty_fwft.sv
// Read-side pointer, empty flag and first-word-fall-through output register of an async FIFO.
// Define RPTR_LEVEL_EN to build the occupancy level, almost-empty and underflow logic.
module rptr_empty_fwft #(
  parameter int ADDRSIZE = 4,
  parameter int DATASIZE = 8,
  parameter int AE_LEVEL = 2
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  input  logic [DATASIZE-1:0] rdata_mem,
  input  logic                rd_en,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic [DATASIZE-1:0] dout,
  output logic                dout_valid,
  output logic                runderflow,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                ralmost_empty
);

  localparam int PW = ADDRSIZE + 1;

  // Handshake: dout_valid offers the word on dout; rd_en pops it only while
  // dout_valid is high, and rd_en with dout_valid low has no effect.
  logic [PW-1:0] rbin;
  logic [PW-1:0] rbinnext;
  logic [PW-1:0] rgraynext;
  logic          load;
  logic          pop;

  // Refill the output register whenever it is empty or being drained this cycle.
  assign load      = ~rempty & (~dout_valid | rd_en);
  assign pop       = rd_en & dout_valid;
  assign rbinnext  = rbin + {{ADDRSIZE{1'b0}}, load};
  assign rgraynext = (rbinnext >> 1) ^ rbinnext;
  assign raddr     = rbin[ADDRSIZE-1:0];

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      rbin       <= '0;
      rptr       <= '0;
      rempty     <= 1'b1;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      rbin   <= rbinnext;
      rptr   <= rgraynext;
      rempty <= (rgraynext == rq2_wptr);
      if (load) begin
        dout       <= rdata_mem;
        dout_valid <= 1'b1;
      end else if (pop) begin
        dout_valid <= 1'b0;
      end
    end
  end

`ifdef RPTR_LEVEL_EN
  logic [PW-1:0] wq2_bin;
  logic [PW-1:0] lvl_next;

  // Each binary bit is the XOR of all Gray bits at and above it.
  always_comb begin
    wq2_bin = '0;
    for (int i = 0; i < PW; i++) begin
      wq2_bin[i] = ^(rq2_wptr >> i);
    end
  end

  // Level is measured against the post-edge read pointer so it matches rempty.
  assign lvl_next = wq2_bin - rbinnext;

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      rlevel        <= '0;
      ralmost_empty <= 1'b1;
      runderflow    <= 1'b0;
    end else begin
      rlevel        <= lvl_next;
      ralmost_empty <= (lvl_next <= PW'(AE_LEVEL));
      runderflow    <= rd_en & ~dout_valid;
    end
  end
`else
  assign rlevel        = '0;
  assign ralmost_empty = 1'b0;
  assign runderflow    = 1'b0;
`endif

endmodule

// File: tb/tb_rptr_empty_fwft.sv
// Self-checking bench for rptr_empty_fwft: a queue-based FIFO model drives the write
// pointer and memory, and every delivered word is checked in order.
module tb_rptr_empty_fwft;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int PW = AW + 1;
`ifdef RPTR_LEVEL_EN
  localparam bit LVL = 1'b1;
`else
  localparam bit LVL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rrst_n = 1'b0;
  logic          rd_en = 1'b0;
  logic [PW-1:0] rq2_wptr = '0;
  logic [DW-1:0] rdata_mem;
  logic [AW-1:0] raddr;
  logic [PW-1:0] rptr;
  logic          rempty;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          runderflow;
  logic [PW-1:0] rlevel;
  logic          ralmost_empty;

  logic [DW-1:0] mem [0:15];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_word;
  int            wbin = 0;
  int            total = 0;
  int            bad = 0;

  always #5 clk = ~clk;

  assign rdata_mem = mem[raddr];

  rptr_empty_fwft #(.ADDRSIZE(AW), .DATASIZE(DW), .AE_LEVEL(2)) dut (
    .rclk(clk), .rrst_n(rrst_n), .rq2_wptr(rq2_wptr), .rdata_mem(rdata_mem),
    .rd_en(rd_en), .raddr(raddr), .rptr(rptr), .rempty(rempty), .dout(dout),
    .dout_valid(dout_valid), .runderflow(runderflow), .rlevel(rlevel),
    .ralmost_empty(ralmost_empty)
  );

  function automatic logic [PW-1:0] gray(input int b);
    logic [PW-1:0] v;
    v = PW'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    mem[wbin % 16] = d;
    wbin = (wbin + 1) % 32;
    rq2_wptr = gray(wbin);
    exp_q.push_back(d);
  endtask

  task automatic do_reset();
    rrst_n = 1'b0;
    rd_en = 1'b0;
    wbin = 0;
    rq2_wptr = '0;
    exp_q.delete();
    tick();
    tick();
    rrst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (rptr !== '0) begin bad++; $display("FAIL reset_rptr got=%b exp=%b", rptr, 5'b0); end
    total++; if (raddr !== '0) begin bad++; $display("FAIL reset_raddr got=%0d exp=0", raddr); end
    total++; if (rempty !== 1'b1) begin bad++; $display("FAIL reset_rempty got=%b exp=1", rempty); end
    total++; if (dout !== '0) begin bad++; $display("FAIL reset_dout got=%h exp=00", dout); end
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL reset_dout_valid got=%b exp=0", dout_valid); end
    total++; if (rlevel !== '0) begin bad++; $display("FAIL reset_rlevel got=%0d exp=0", rlevel); end
    total++; if (ralmost_empty !== LVL) begin bad++; $display("FAIL reset_ae got=%b exp=%b", ralmost_empty, LVL); end
    total++; if (runderflow !== 1'b0) begin bad++; $display("FAIL reset_underflow got=%b exp=0", runderflow); end
  endtask

  task automatic test_first_word();
    push_word(8'hA5);
    rd_en = 1'b0;
    tick();
    total++; if (rempty !== 1'b0) begin bad++; $display("FAIL fw_rempty_e1 got=%b exp=0", rempty); end
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL fw_valid_e1 got=%b exp=0", dout_valid); end
    tick();
    total++; if (dout !== 8'hA5) begin bad++; $display("FAIL fw_dout_e2 got=%h exp=a5", dout); end
    total++; if (dout_valid !== 1'b1) begin bad++; $display("FAIL fw_valid_e2 got=%b exp=1", dout_valid); end
    total++; if (rempty !== 1'b1) begin bad++; $display("FAIL fw_rempty_e2 got=%b exp=1", rempty); end
    total++; if (rptr !== gray(1)) begin bad++; $display("FAIL fw_rptr got=%b exp=%b", rptr, gray(1)); end
    rd_en = 1'b1;
    last_word = exp_q.pop_front();
    tick();
    rd_en = 1'b0;
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL fw_pop_valid got=%b exp=0", dout_valid); end
  endtask

  task automatic test_preload();
    do_reset();
    for (int i = 0; i < 16; i++) push_word(DW'($urandom_range(0, 255)));
    rd_en = 1'b1;
    tick();
    total++; if (rempty !== 1'b0) begin bad++; $display("FAIL pre_rempty_e1 got=%b exp=0", rempty); end
    tick();
    for (int i = 0; i < 16; i++) begin
      total++; if (dout_valid !== 1'b1) begin bad++; $display("FAIL pre_valid[%0d] got=%b exp=1", i, dout_valid); end
      total++; if (dout !== exp_q[0]) begin bad++; $display("FAIL pre_dout[%0d] got=%h exp=%h", i, dout, exp_q[0]); end
      last_word = exp_q.pop_front();
      tick();
    end
    rd_en = 1'b0;
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL pre_end_valid got=%b exp=0", dout_valid); end
    total++; if (rptr !== 5'b11000) begin bad++; $display("FAIL pre_end_rptr got=%b exp=11000", rptr); end
    total++; if (rempty !== 1'b1) begin bad++; $display("FAIL pre_end_rempty got=%b exp=1", rempty); end
  endtask

  task automatic test_stream_wrap();
    int pushed = 0;
    int popped = 0;
    int cyc = 0;
    bit saw_raddr_wrap = 1'b0;
    bit saw_ptr_wrap = 1'b0;
    logic [AW-1:0] prev_raddr;
    logic [PW-1:0] prev_rptr;
    prev_raddr = raddr;
    prev_rptr = rptr;
    while (popped < 40 && cyc < 3000) begin
      rd_en = ($urandom_range(0, 3) != 0);
      if (rd_en && dout_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL stream_dout got=%h exp=<none queued>", dout);
        end else begin
          if (dout !== exp_q[0]) begin bad++; $display("FAIL stream_dout[%0d] got=%h exp=%h", popped, dout, exp_q[0]); end
          last_word = exp_q.pop_front();
        end
        popped++;
      end
      if (pushed < 40 && exp_q.size() < 16 && $urandom_range(0, 2) != 0) begin
        push_word(DW'($urandom_range(0, 255)));
        pushed++;
      end
      tick();
      cyc++;
      if (prev_raddr == 4'd15 && raddr == 4'd0) saw_raddr_wrap = 1'b1;
      if (prev_rptr == 5'b10000 && rptr == 5'b00000) saw_ptr_wrap = 1'b1;
      prev_raddr = raddr;
      prev_rptr = rptr;
    end
    rd_en = 1'b0;
    total++; if (popped != 40) begin bad++; $display("FAIL stream_timeout popped=%0d exp=40", popped); end
    total++; if (!saw_raddr_wrap) begin bad++; $display("FAIL stream_raddr_wrap seen=0 exp=1"); end
    total++; if (!saw_ptr_wrap) begin bad++; $display("FAIL stream_rptr_wrap seen=0 exp=1"); end
    tick();
    tick();
    total++; if (rempty !== 1'b1) begin bad++; $display("FAIL stream_end_rempty got=%b exp=1", rempty); end
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL stream_end_valid got=%b exp=0", dout_valid); end
    total++; if (rptr !== gray(wbin)) begin bad++; $display("FAIL stream_end_rptr got=%b exp=%b", rptr, gray(wbin)); end
    total++; if (rlevel !== '0) begin bad++; $display("FAIL stream_end_rlevel got=%0d exp=0", rlevel); end
    total++; if (ralmost_empty !== LVL) begin bad++; $display("FAIL stream_end_ae got=%b exp=%b", ralmost_empty, LVL); end
  endtask

  task automatic test_underflow();
    total++; if (runderflow !== 1'b0) begin bad++; $display("FAIL uf_before got=%b exp=0", runderflow); end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    total++; if (rptr !== gray(wbin)) begin bad++; $display("FAIL uf_rptr got=%b exp=%b", rptr, gray(wbin)); end
    total++; if (raddr !== AW'(wbin % 16)) begin bad++; $display("FAIL uf_raddr got=%0d exp=%0d", raddr, wbin % 16); end
    total++; if (dout !== last_word) begin bad++; $display("FAIL uf_dout got=%h exp=%h", dout, last_word); end
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL uf_valid got=%b exp=0", dout_valid); end
    total++; if (runderflow !== LVL) begin bad++; $display("FAIL uf_pulse got=%b exp=%b", runderflow, LVL); end
    tick();
    total++; if (runderflow !== 1'b0) begin bad++; $display("FAIL uf_after got=%b exp=0", runderflow); end
  endtask

  task automatic test_level();
    logic [PW-1:0] exp_lvl;
    int loaded;
    do_reset();
    for (int i = 0; i < 5; i++) push_word(DW'($urandom_range(0, 255)));
    tick();
    exp_lvl = LVL ? PW'(5) : '0;
    total++; if (rlevel !== exp_lvl) begin bad++; $display("FAIL lvl_e1 got=%0d exp=%0d", rlevel, exp_lvl); end
    total++; if (ralmost_empty !== 1'b0) begin bad++; $display("FAIL lvl_ae_e1 got=%b exp=0", ralmost_empty); end
    tick();
    loaded = 1;
    exp_lvl = LVL ? PW'(4) : '0;
    total++; if (dout_valid !== 1'b1) begin bad++; $display("FAIL lvl_valid got=%b exp=1", dout_valid); end
    total++; if (rlevel !== exp_lvl) begin bad++; $display("FAIL lvl_e2 got=%0d exp=%0d", rlevel, exp_lvl); end
    total++; if (ralmost_empty !== 1'b0) begin bad++; $display("FAIL lvl_ae_e2 got=%b exp=0", ralmost_empty); end
    for (int i = 0; i < 4; i++) begin
      rd_en = 1'b1;
      total++; if (dout !== exp_q[0]) begin bad++; $display("FAIL lvl_dout[%0d] got=%h exp=%h", i, dout, exp_q[0]); end
      last_word = exp_q.pop_front();
      tick();
      loaded++;
      exp_lvl = LVL ? PW'(5 - loaded) : '0;
      total++; if (rlevel !== exp_lvl) begin bad++; $display("FAIL lvl_step[%0d] got=%0d exp=%0d", i, rlevel, exp_lvl); end
      total++;
      if (ralmost_empty !== (LVL && (5 - loaded) <= 2)) begin
        bad++; $display("FAIL lvl_ae_step[%0d] got=%b exp=%b", i, ralmost_empty, (LVL && (5 - loaded) <= 2));
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_reset_midstream();
    total++; if (dout_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid got=%b exp=1", dout_valid); end
    rd_en = 1'b1;
    rrst_n = 1'b0;
    tick();
    total++; if (rptr !== '0) begin bad++; $display("FAIL mid_rptr got=%b exp=00000", rptr); end
    total++; if (raddr !== '0) begin bad++; $display("FAIL mid_raddr got=%0d exp=0", raddr); end
    total++; if (rempty !== 1'b1) begin bad++; $display("FAIL mid_rempty got=%b exp=1", rempty); end
    total++; if (dout !== '0) begin bad++; $display("FAIL mid_dout got=%h exp=00", dout); end
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", dout_valid); end
    total++; if (rlevel !== '0) begin bad++; $display("FAIL mid_rlevel got=%0d exp=0", rlevel); end
    total++; if (ralmost_empty !== LVL) begin bad++; $display("FAIL mid_ae got=%b exp=%b", ralmost_empty, LVL); end
    total++; if (runderflow !== 1'b0) begin bad++; $display("FAIL mid_underflow got=%b exp=0", runderflow); end
    do_reset();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    test_reset();
    test_first_word();
    test_preload();
    test_stream_wrap();
    test_underflow();
    test_level();
    test_reset_midstream();
    test_first_word();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rptr_empty_fwft.md
RPTR_EMPTY_FWFT -- requirements
Module: rptr_empty_fwft

Interface
REQ-001 The block SHALL provide parameter ADDRSIZE, default 4, meaning memory address width; FIFO depth is 2**ADDRSIZE.
REQ-002 The block SHALL provide parameter DATASIZE, default 8, meaning data word width.
REQ-003 The block SHALL provide parameter AE_LEVEL, default 2, meaning the almost-empty threshold in words.
REQ-004 The block SHALL have port rclk, input, 1 bit, read-domain clock; the block SHALL use one clock only.
REQ-005 The block SHALL have port rrst_n, input, 1 bit, reset; the reset SHALL be synchronous and active-low.
REQ-006 The block SHALL have port rq2_wptr, input, ADDRSIZE+1 bits, the Gray write pointer already synchronized into rclk.
REQ-007 The block SHALL have port rdata_mem, input, DATASIZE bits, memory read data, combinationally valid for the current raddr.
REQ-008 The block SHALL have port rd_en, input, 1 bit, consumer pop of the word on dout.
REQ-009 The block SHALL have port raddr, output, ADDRSIZE bits, memory read address, equal to rbin[ADDRSIZE-1:0].
REQ-010 The block SHALL have port rptr, output, ADDRSIZE+1 bits, registered Gray read pointer sent to the write domain.
REQ-011 The block SHALL have port rempty, output, 1 bit, registered flag meaning the memory holds no unread word.
REQ-012 The block SHALL have port dout, output, DATASIZE bits, registered head-of-FIFO word in first-word-fall-through style.
REQ-013 The block SHALL have port dout_valid, output, 1 bit, meaning dout holds a valid word.
REQ-014 The block SHALL have port runderflow, output, 1 bit, a one-cycle pulse.
REQ-015 The block SHALL have port rlevel, output, ADDRSIZE+1 bits, memory occupancy.
REQ-016 The block SHALL have port ralmost_empty, output, 1 bit, low-occupancy flag.

Function
REQ-017 The block SHALL compute internal load = ~rempty & (~dout_valid | rd_en).
REQ-018 The block SHALL compute rbinnext = rbin + load, with modulo 2**(ADDRSIZE+1) wrap.
REQ-019 The block SHALL compute rgraynext = (rbinnext >> 1) ^ rbinnext.
REQ-020 On every rclk edge the block SHALL register rbin <= rbinnext, rptr <= rgraynext, and rempty <= (rgraynext == rq2_wptr).
REQ-021 When load is 1, the block SHALL register dout <= rdata_mem and dout_valid <= 1.
REQ-022 When load is 0 and rd_en & dout_valid is 1, the block SHALL clear dout_valid and hold dout.
REQ-023 When neither load nor pop occurs, the block SHALL hold dout and dout_valid.
REQ-024 Latency: after rq2_wptr departs from rptr with the FIFO idle, rempty SHALL deassert at the 1st rclk edge and dout_valid SHALL assert at the 2nd edge.
REQ-025 Throughput: with dout_valid=1, rd_en=1 held, and rempty=0, the block SHALL deliver one new word per cycle with no bubble.
REQ-026 rd_en while dout_valid=0 SHALL be ignored: no pointer change, no data change.
REQ-027 Simultaneous pop and load SHALL replace dout with the next word, and dout_valid SHALL stay 1.
REQ-028 Pointer wrap from 2**(ADDRSIZE+1)-1 to 0 SHALL be seamless; the rempty compare SHALL use full-width Gray values.
REQ-029 The block SHALL never advance rbin while rempty=1.

Reset
REQ-030 When rrst_n=0 at an rclk edge, the block SHALL set rbin=0, rptr=0, rempty=1, dout=0, dout_valid=0, runderflow=0, rlevel=0, and ralmost_empty=1.
REQ-031 Reset asserted mid-stream SHALL discard the dout word and take priority over load and rd_en.
REQ-032 After release, the block SHALL behave as from power-up.

Configuration
REQ-033 Macro RPTR_LEVEL_EN SHALL control the level, almost-empty, and underflow logic.
REQ-034 With RPTR_LEVEL_EN defined, the block SHALL decode rq2_wptr Gray-to-binary into wq2_bin.
REQ-035 With RPTR_LEVEL_EN defined, the block SHALL register rlevel <= wq2_bin - rbinnext, modulo 2**(ADDRSIZE+1).
REQ-036 With RPTR_LEVEL_EN defined, the block SHALL register ralmost_empty <= ((wq2_bin - rbinnext) <= AE_LEVEL).
REQ-037 With RPTR_LEVEL_EN defined, the block SHALL register runderflow <= rd_en & ~dout_valid.
REQ-038 Without RPTR_LEVEL_EN, rlevel, ralmost_empty, and runderflow SHALL be constant 0, no decode logic SHALL exist, and ports SHALL be unchanged.

Verification
REQ-039 The bench SHALL drive reset, then rq2_wptr from 00000 to 00001 with rdata_mem=8'hA5, rd_en=0; rempty SHALL be 0 at edge 1, dout=A5 and dout_valid=1 at edge 2, and rempty SHALL be 1 again at edge 2.
REQ-040 The bench SHALL preload 16 words with rq2_wptr=Gray(16)=11000 and hold rd_en=1; 16 consecutive dout values SHALL appear, then dout_valid=0, rptr=11000, and rempty=1.
REQ-041 The bench SHALL stream 40 words with rq2_wptr advancing across the 31-to-0 wrap; the data order SHALL be preserved and raddr SHALL wrap 15 to 0.
REQ-042 The bench SHALL pulse rd_en with dout_valid=0; there SHALL be no change to rbin or dout, and with RPTR_LEVEL_EN runderflow=1 for one cycle.
REQ-043 With RPTR_LEVEL_EN, the bench SHALL apply rq2_wptr=Gray(5) at rbin=0 with rd_en=0; after the first load it SHALL see rlevel=4 and ralmost_empty=0, and once rlevel<=2 it SHALL see ralmost_empty=1.
REQ-044 The bench SHALL drop rrst_n mid-stream while dout_valid=1; at the next edge it SHALL see all outputs at their reset values, even with rd_en=1.
